// File: rtl/rs_alu_station.sv
// Reservation station for ALU/branch ops: operand capture, broadcast snoop, one dispatch per cycle.
// Optional RS_OLDEST_FIRST_EN: age-ordered dispatch instead of lowest-index dispatch.
module rs_alu_station #(
  parameter int unsigned RS_SIZE = 8,
  parameter int unsigned ROB_BIT = 4
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               clear_up,
  input  logic               issue_valid,
  input  logic [ROB_BIT-1:0] issue_rob_entry,
  input  logic [6:0]         issue_op_type,
  input  logic [2:0]         issue_op,
  input  logic               issue_alt,
  input  logic               issue_r1,
  input  logic               issue_r2,
  input  logic [31:0]        issue_v1,
  input  logic [31:0]        issue_v2,
  input  logic [ROB_BIT-1:0] issue_q1,
  input  logic [ROB_BIT-1:0] issue_q2,
  output logic               rs_full,
  input  logic               rs_ready_bd,
  input  logic [ROB_BIT-1:0] rs_rob_entry,
  input  logic [31:0]        rs_value,
  input  logic               lsb_ready_bd,
  input  logic [ROB_BIT-1:0] lsb_rob_entry,
  input  logic [31:0]        lsb_value,
  output logic               alu_valid,
  output logic [6:0]         alu_op_type,
  output logic [2:0]         alu_op,
  output logic               alu_alt,
  output logic [31:0]        alu_v1,
  output logic [31:0]        alu_v2,
  output logic [ROB_BIT-1:0] alu_rob_entry
);

  localparam int unsigned IDX_W = $clog2(RS_SIZE);
  localparam int unsigned CNT_W = IDX_W + 1;

  logic [RS_SIZE-1:0] r_busy;
  logic [RS_SIZE-1:0] r_r1;
  logic [RS_SIZE-1:0] r_r2;
  logic [RS_SIZE-1:0] r_alt;
  logic [31:0]        r_v1      [RS_SIZE];
  logic [31:0]        r_v2      [RS_SIZE];
  logic [ROB_BIT-1:0] r_q1      [RS_SIZE];
  logic [ROB_BIT-1:0] r_q2      [RS_SIZE];
  logic [ROB_BIT-1:0] r_rob     [RS_SIZE];
  logic [6:0]         r_op_type [RS_SIZE];
  logic [2:0]         r_op      [RS_SIZE];
  logic [CNT_W-1:0]   r_count;
`ifdef RS_OLDEST_FIRST_EN
  logic [IDX_W-1:0]   r_age     [RS_SIZE];
  logic [IDX_W-1:0]   w_sel_age;
`endif

  logic               r_alu_valid;
  logic [6:0]         r_alu_op_type;
  logic [2:0]         r_alu_op;
  logic               r_alu_alt;
  logic [31:0]        r_alu_v1;
  logic [31:0]        r_alu_v2;
  logic [ROB_BIT-1:0] r_alu_rob;

  logic [RS_SIZE-1:0] w_ready;
  logic               w_sel_valid;
  logic [IDX_W-1:0]   w_sel_idx;
  logic               w_free_valid;
  logic [IDX_W-1:0]   w_free_idx;
  logic               w_do_issue;
  logic               w_iss_r1;
  logic               w_iss_r2;
  logic [31:0]        w_iss_v1;
  logic [31:0]        w_iss_v2;

  assign w_ready    = r_busy & r_r1 & r_r2;
  assign rs_full    = (r_count == CNT_W'(RS_SIZE));
  assign w_do_issue = issue_valid && !rs_full && w_free_valid;

  // Operand capture at issue; the LSB broadcast takes priority over the RS broadcast.
  always_comb begin
    w_iss_r1 = issue_r1;
    w_iss_v1 = issue_v1;
    w_iss_r2 = issue_r2;
    w_iss_v2 = issue_v2;
    if (!issue_r1) begin
      if (lsb_ready_bd && lsb_rob_entry == issue_q1) begin
        w_iss_r1 = 1'b1;
        w_iss_v1 = lsb_value;
      end else if (rs_ready_bd && rs_rob_entry == issue_q1) begin
        w_iss_r1 = 1'b1;
        w_iss_v1 = rs_value;
      end
    end
    if (!issue_r2) begin
      if (lsb_ready_bd && lsb_rob_entry == issue_q2) begin
        w_iss_r2 = 1'b1;
        w_iss_v2 = lsb_value;
      end else if (rs_ready_bd && rs_rob_entry == issue_q2) begin
        w_iss_r2 = 1'b1;
        w_iss_v2 = rs_value;
      end
    end
  end

  always_comb begin
    w_free_valid = 1'b0;
    w_free_idx   = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (!r_busy[i] && !w_free_valid) begin
        w_free_valid = 1'b1;
        w_free_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_idx   = '0;
`ifdef RS_OLDEST_FIRST_EN
    w_sel_age   = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (w_ready[i] && (!w_sel_valid || r_age[i] < w_sel_age)) begin
        w_sel_valid = 1'b1;
        w_sel_idx   = IDX_W'(i);
        w_sel_age   = r_age[i];
      end
    end
`else
    for (int i = 0; i < RS_SIZE; i++) begin
      if (w_ready[i] && !w_sel_valid) begin
        w_sel_valid = 1'b1;
        w_sel_idx   = IDX_W'(i);
      end
    end
`endif
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_busy        <= '0;
      r_r1          <= '0;
      r_r2          <= '0;
      r_alt         <= '0;
      r_count       <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        r_v1[i]      <= '0;
        r_v2[i]      <= '0;
        r_q1[i]      <= '0;
        r_q2[i]      <= '0;
        r_rob[i]     <= '0;
        r_op_type[i] <= '0;
        r_op[i]      <= '0;
`ifdef RS_OLDEST_FIRST_EN
        r_age[i]     <= '0;
`endif
      end
      r_alu_valid   <= 1'b0;
      r_alu_op_type <= '0;
      r_alu_op      <= '0;
      r_alu_alt     <= 1'b0;
      r_alu_v1      <= '0;
      r_alu_v2      <= '0;
      r_alu_rob     <= '0;
    end else if (rdy_in) begin
      if (clear_up) begin
        r_busy      <= '0;
        r_count     <= '0;
        r_alu_valid <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (r_busy[i] && !r_r1[i]) begin
            if (lsb_ready_bd && lsb_rob_entry == r_q1[i]) begin
              r_r1[i] <= 1'b1;
              r_v1[i] <= lsb_value;
            end else if (rs_ready_bd && rs_rob_entry == r_q1[i]) begin
              r_r1[i] <= 1'b1;
              r_v1[i] <= rs_value;
            end
          end
          if (r_busy[i] && !r_r2[i]) begin
            if (lsb_ready_bd && lsb_rob_entry == r_q2[i]) begin
              r_r2[i] <= 1'b1;
              r_v2[i] <= lsb_value;
            end else if (rs_ready_bd && rs_rob_entry == r_q2[i]) begin
              r_r2[i] <= 1'b1;
              r_v2[i] <= rs_value;
            end
          end
`ifdef RS_OLDEST_FIRST_EN
          // Younger entries close the gap left by the dispatched one, keeping ages dense.
          if (w_sel_valid && r_busy[i] && r_age[i] > w_sel_age)
            r_age[i] <= r_age[i] - IDX_W'(1);
`endif
        end
        r_alu_valid <= w_sel_valid;
        if (w_sel_valid) begin
          r_busy[w_sel_idx] <= 1'b0;
          r_alu_op_type     <= r_op_type[w_sel_idx];
          r_alu_op          <= r_op[w_sel_idx];
          r_alu_alt         <= r_alt[w_sel_idx];
          r_alu_v1          <= r_v1[w_sel_idx];
          r_alu_v2          <= r_v2[w_sel_idx];
          r_alu_rob         <= r_rob[w_sel_idx];
        end
        if (w_do_issue) begin
          r_busy[w_free_idx]    <= 1'b1;
          r_r1[w_free_idx]      <= w_iss_r1;
          r_v1[w_free_idx]      <= w_iss_v1;
          r_q1[w_free_idx]      <= issue_q1;
          r_r2[w_free_idx]      <= w_iss_r2;
          r_v2[w_free_idx]      <= w_iss_v2;
          r_q2[w_free_idx]      <= issue_q2;
          r_rob[w_free_idx]     <= issue_rob_entry;
          r_op_type[w_free_idx] <= issue_op_type;
          r_op[w_free_idx]      <= issue_op;
          r_alt[w_free_idx]     <= issue_alt;
`ifdef RS_OLDEST_FIRST_EN
          r_age[w_free_idx]     <= IDX_W'(r_count - CNT_W'(w_sel_valid));
`endif
        end
        case ({w_do_issue, w_sel_valid})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  assign alu_valid     = r_alu_valid;
  assign alu_op_type   = r_alu_op_type;
  assign alu_op        = r_alu_op;
  assign alu_alt       = r_alu_alt;
  assign alu_v1        = r_alu_v1;
  assign alu_v2        = r_alu_v2;
  assign alu_rob_entry = r_alu_rob;

endmodule

// File: doc/rs_alu_station.md
# rs_alu_station

Reservation station for ALU and branch instructions. Sits between the decoder/issue logic and the ALU, alongside the reorder buffer. It holds issued instructions until both source operands are available, snooping the RS and LSB result broadcasts that also feed the ROB. It dispatches one ready instruction per cycle to the ALU, and its own ALU results return on the `rs_ready_bd` broadcast.

## Interface
- `RS_SIZE`, 8, number of entries (power of two, ≥2)
- `ROB_BIT`, 4, width of a ROB entry tag
- `clk_in`  in  1  system clock
- `rst_in`  in  1  reset, asynchronous, active-low
- `rdy_in`  in  1  global stall when low; no state changes
- `clear_up`  in  1  mispredict flush from ROB
- `issue_valid`  in  1  new instruction this cycle
- `issue_rob_entry`  in  ROB_BIT  destination ROB tag
- `issue_op_type`  in  7  major opcode
- `issue_op`  in  3  funct3
- `issue_alt`  in  1  funct7[5] (SUB/SRA select)
- `issue_r1`, `issue_r2`  in  1  operand already valid
- `issue_v1`, `issue_v2`  in  32  operand value (used when r=1)
- `issue_q1`, `issue_q2`  in  ROB_BIT  producer tag (used when r=0)
- `rs_full`  out  1  no free entry
- `rs_ready_bd`, `lsb_ready_bd`  in  1  broadcast valid
- `rs_rob_entry`, `lsb_rob_entry`  in  ROB_BIT  broadcast tag
- `rs_value`, `lsb_value`  in  32  broadcast value
- `alu_valid`  out  1  dispatch valid (registered)
- `alu_op_type`  out  7, `alu_op`  out  3, `alu_alt`  out  1  operation
- `alu_v1`, `alu_v2`  out  32  operand values
- `alu_rob_entry`  out  ROB_BIT  tag carried to result broadcast

## Operation
- Per entry: busy, op fields, r1/v1/q1, r2/v2/q2, rob tag.
- Issue: when `issue_valid`, write the lowest-index free entry. The issuer must not assert `issue_valid` while `rs_full`; if it does, the request is dropped.
- Issue-time capture:
  - If `issue_r*`=0 and a broadcast in the same cycle matches `issue_q*`, store the broadcast value with r=1.
  - If both broadcasts match, LSB wins.
- Snoop: every cycle, each busy entry with r=0 whose q matches a valid broadcast takes that value and sets r=1. Both operands may resolve in the same cycle.
- Dispatch:
  - An entry is ready when busy && r1 && r2, using registered state only.
  - At most one entry is selected per cycle. The selected entry is copied to the `alu_*` registers, `alu_valid` is set to 1, and the entry is freed.
  - If no entry is ready, `alu_valid` is set to 0.
- Dispatch and issue in the same cycle are legal. A freed entry is reusable from the next cycle.
- Flush: `clear_up`&&`rdy_in` clears all busy bits and `alu_valid`. Any issue or snoop in that cycle is ignored.
- `rdy_in`=0: all registers hold, including `alu_valid`.
- Occupancy counter:
  - Counts from 0 to RS_SIZE; width is log2(RS_SIZE)+1.
  - Issue without dispatch: +1. Dispatch without issue: −1. Both or neither: unchanged.
  - `rs_full` = (count == RS_SIZE), registered-derived.

## Timing
- Reset (`rst_in` low, asynchronous):
  - All busy bits cleared; count = 0.
  - `rs_full`=0, `alu_valid`=0.
  - `alu_v1`/`alu_v2`=0, `alu_rob_entry`=0, `alu_op_type`/`alu_op`/`alu_alt`=0.
  - Deasserting reset mid-operation resumes from the empty state.
- Issue in cycle N with both operands ready: `alu_valid` is high in cycle N+2 at the earliest (entry written at end of N, selected at end of N+1).
- Broadcast in cycle N completing an entry: `alu_valid` is high in N+2 at the earliest.
- `alu_valid` is a single-cycle pulse per dispatched entry. The ALU always accepts, so there is no backpressure.
- `rs_full` updates in the cycle after the occupancy change.

## Configuration
- `RS_OLDEST_FIRST_EN` defined:
  - Each entry carries a log2(RS_SIZE)-bit age.
  - An entry's age is set to the current count of busy entries at issue, and decremented when an older entry dispatches.
  - Dispatch selects the ready entry with the smallest age.
- Not defined: dispatch selects the lowest-index ready entry, and no age storage is built.

## Test plan
- Reset, then issue ADD with r1=r2=1, v1=5, v2=7, tag 3 → two cycles later `alu_valid`=1, v1=5, v2=7, `alu_rob_entry`=3; `alu_valid` is 0 the following cycle.
- Issue with q1=2, r1=0. Three cycles later assert `rs_ready_bd` with tag 2, value 0x1234 → dispatch two cycles after the broadcast with `alu_v1`=0x1234.
- Issue with q2=6 in the same cycle that `lsb_ready_bd` carries tag 6, value 0xAB → entry dispatches with `alu_v2`=0xAB and no further broadcast is needed.
- Issue 8 unready entries → `rs_full`=1; broadcast readiness for one entry → it dispatches, and `rs_full` is 0 the next cycle.
- Fill 4 pending entries, then assert `clear_up` → all entries are gone; later broadcasts of their tags produce no `alu_valid`; count = 0.
- With `RS_OLDEST_FIRST_EN`: issue A (not ready, entry 0), B, C; make C then A ready in the same cycle → A dispatches first, C next. Without the macro, the order is the same here because A is at index 0. Repeat after A has been freed and reallocated to verify the age-based ordering.
